// File: rtl/n2t_pkg.sv
// rtl/n2t_pkg.sv - shared constants for the and16 datapath blocks
package n2t_pkg;

    localparam int   DATA_W  = 16;
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RESP = 1'b1;

endpackage

// File: rtl/and16_bit.sv
// rtl/and16_bit.sv - gate-level 16-bit bitwise AND unit
module and16_bit
    import n2t_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    for (genvar i = 0; i < DATA_W; i++) begin : g_bit
        and u_and (y[i], a[i], b[i]);
    end

endmodule

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational round-robin pick starting at ptr
module rr_priority_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] winner,
    output logic          any
);

    int idx;

    // Scan from farthest offset down so the nearest requester at/after ptr wins.
    always_comb begin
        winner = '0;
        idx    = 0;
        any    = |req;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx]) begin
                winner = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/and16_rr_arbiter.sv
// rtl/and16_rr_arbiter.sv - round-robin shared and16_bit with tagged response
module and16_rr_arbiter
    import n2t_pkg::*;
#(
    parameter int WIDTH   = DATA_W,
    parameter int NUM_REQ = 4,
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [IDW-1:0]           rsp_id,
    output logic                     busy
);

    logic             state;
    logic             state_nxt;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   winner;
    logic             any;
    logic             can_grant;
    logic             grant;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] and_y;

    rr_priority_pick #(
        .N  (NUM_REQ),
        .IW (IDW)
    ) u_pick (
        .req    (req_valid),
        .ptr    (ptr),
        .winner (winner),
        .any    (any)
    );

    assign op_a = req_a[int'(winner)*WIDTH +: WIDTH];
    assign op_b = req_b[int'(winner)*WIDTH +: WIDTH];

    and16_bit u_and (
        .a (op_a),
        .b (op_b),
        .y (and_y)
    );

    // A held response blocks new grants unless it is being consumed this cycle.
    assign can_grant = (state == ST_IDLE) | rsp_ready;
    assign grant     = can_grant & any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            rsp_data <= '0;
            rsp_id   <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                rsp_data <= and_y;
                rsp_id   <= winner;
                ptr      <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + IDW'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (grant) begin
            state_nxt = ST_RESP;
        end else if ((state == ST_RESP) && rsp_ready) begin
            state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        rsp_valid = (state == ST_RESP);
        busy      = (state == ST_RESP);
        req_ready = '0;
        if (rst_n && grant) begin
            req_ready = NUM_REQ'(1) << winner;
        end
    end

endmodule
